// File: rtl/cpu_run_ctrl_if.sv
// ---------------------------------------------------------------------------
// cpu_run_ctrl_if
//   Groups the run-control handshake between a host/test harness and the
//   cpu_run_ctrl block.
//
//   Signals
//     start      host -> ctrl : request a new run (honoured in IDLE/DONE)
//     halt       host -> ctrl : CPU end-of-program indication
//     step_mode  host -> ctrl : 1 = CPU advances only on step
//     step       host -> ctrl : level-sampled single-cycle advance request
//     cpu_reset  ctrl -> host : reset to the CPU
//     cpu_en     ctrl -> host : clock enable to the CPU (combinational)
//     cycles     ctrl -> host : enabled cycles in the current/last run
//     done       ctrl -> host : run finished
//     timeout    ctrl -> host : run ended on budget exhaustion, not halt
//
//   Modports
//     master : host side (drives requests, observes status)
//     slave  : cpu_run_ctrl side
// ---------------------------------------------------------------------------
interface cpu_run_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             start;
    logic             halt;
    logic             step_mode;
    logic             step;
    logic             cpu_reset;
    logic             cpu_en;
    logic [CNT_W-1:0] cycles;
    logic             done;
    logic             timeout;

    modport master (
        output start, halt, step_mode, step,
        input  cpu_reset, cpu_en, cycles, done, timeout
    );

    modport slave (
        input  start, halt, step_mode, step,
        output cpu_reset, cpu_en, cycles, done, timeout
    );
endinterface

// File: rtl/cpu_run_ctrl.sv
// ---------------------------------------------------------------------------
// cpu_run_ctrl
//   Run controller for a CPU under test. On start it holds the CPU in reset
//   for RST_CYCLES cycles, then clock-enables it until either the CPU raises
//   halt or the enabled-cycle budget MAX_CYCLES is used up (0 = no budget).
//   Optional single-step mode gates the enable with a level-sampled step.
//
//   Parameters
//     CNT_W       cycle counter width (counter saturates, never wraps)
//     RST_CYCLES  cycles cpu_reset is held after start (1..255)
//     MAX_CYCLES  enabled-cycle budget, 0 = unlimited
//
//   Ports
//     clk    rising-edge clock
//     reset  synchronous, active-high
//     bus    cpu_run_ctrl_if.slave (start/halt/step_mode/step in,
//            cpu_reset/cpu_en/cycles/done/timeout out)
// ---------------------------------------------------------------------------
module cpu_run_ctrl #(
    parameter int CNT_W      = 16,
    parameter int RST_CYCLES = 2,
    parameter int MAX_CYCLES = 50
) (
    input  logic           clk,
    input  logic           reset,
    cpu_run_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RST  = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_SAT     = '1;
    localparam bit               HAS_BUDGET  = (MAX_CYCLES != 0);
    // Value of cycles during the final budgeted enabled cycle.
    localparam logic [CNT_W-1:0] BUDGET_LAST =
        CNT_W'((MAX_CYCLES == 0) ? 0 : MAX_CYCLES - 1);
    // The down-counter is loaded on the start edge, so the RST state lasts
    // RST_CYCLES cycles when it runs from RST_CYCLES-1 down to 0.
    localparam logic [7:0]       RST_LOAD    = 8'(RST_CYCLES - 1);

    state_t           state, state_nx;
    logic [7:0]       rst_cnt, rst_cnt_nx;
    logic [CNT_W-1:0] cycles_q, cycles_nx;
    logic             timeout_q, timeout_nx;
    logic             cpu_en;

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            rst_cnt   <= '0;
            cycles_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            state     <= state_nx;
            rst_cnt   <= rst_cnt_nx;
            cycles_q  <= cycles_nx;
            timeout_q <= timeout_nx;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and enable logic
    // ------------------------------------------------------------------
    always_comb begin
        state_nx   = state;
        rst_cnt_nx = rst_cnt;
        cycles_nx  = cycles_q;
        timeout_nx = timeout_q;

        // Combinational so step_mode/step/halt act in the same cycle.
        cpu_en = (state == RUN) && !bus.halt && (!bus.step_mode || bus.step);

        case (state)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_nx   = RST;
                    rst_cnt_nx = RST_LOAD;
                    cycles_nx  = '0;
                    timeout_nx = 1'b0;
                end
            end

            RST: begin
                if (rst_cnt == 8'd0) begin
                    state_nx = RUN;
                end else begin
                    rst_cnt_nx = rst_cnt - 8'd1;
                end
            end

            RUN: begin
                // halt beats the budget: cpu_en is already low, so the
                // count is not advanced and timeout stays clear.
                if (bus.halt) begin
                    state_nx = DONE;
                end else if (cpu_en) begin
                    if (cycles_q != CNT_SAT) begin
                        cycles_nx = cycles_q + 1'b1;
                    end
                    if (HAS_BUDGET && (cycles_q == BUDGET_LAST)) begin
                        state_nx   = DONE;
                        timeout_nx = 1'b1;
                    end
                end
            end

            default: state_nx = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // reset is folded in so the CPU sits in reset from power-up, before
    // the first clock edge has forced the FSM to IDLE.
    assign bus.cpu_reset = reset || (state == IDLE) || (state == RST);
    assign bus.cpu_en    = cpu_en;
    assign bus.cycles    = cycles_q;
    assign bus.done      = (state == DONE);
    assign bus.timeout   = timeout_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// ---------------------------------------------------------------------------
// tb_cpu_run_ctrl
//   Three cpu_run_ctrl instances with different parameters share one set of
//   stimulus. Each cycle the stimulus task computes, from a run-level model
//   (phase + start timestamp + unbounded enabled count), what every
//   instance should show and queues it; a negedge monitor pops and compares.
//   Directed spot checks ride the same monitor through a second queue.
//     dut0: CNT_W=16 RST_CYCLES=2 MAX_CYCLES=50
//     dut1: CNT_W=16 RST_CYCLES=1 MAX_CYCLES=5
//     dut2: CNT_W=4  RST_CYCLES=3 MAX_CYCLES=0
// ---------------------------------------------------------------------------
module tb_cpu_run_ctrl;

    localparam int PR   [3] = '{2, 1, 3};
    localparam int PM   [3] = '{50, 5, 0};
    localparam int PCAP [3] = '{65535, 65535, 15};

    localparam int PH_IDLE = 0;
    localparam int PH_RST  = 1;
    localparam int PH_RUN  = 2;
    localparam int PH_DONE = 3;

    localparam int F_RST = 0;
    localparam int F_EN  = 1;
    localparam int F_DN  = 2;
    localparam int F_TO  = 3;
    localparam int F_CYC = 4;

    typedef struct packed {
        logic        rst;
        logic        en;
        logic        dn;
        logic        to;
        logic [15:0] cyc;
    } obs_t;

    typedef struct {
        int k;
        int fld;
        int val;
    } dir_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset     = 1'b1;
    logic start     = 1'b0;
    logic halt      = 1'b0;
    logic step_mode = 1'b0;
    logic step      = 1'b0;

    cpu_run_ctrl_if #(.CNT_W(16)) if0 ();
    cpu_run_ctrl_if #(.CNT_W(16)) if1 ();
    cpu_run_ctrl_if #(.CNT_W(4))  if2 ();

    assign if0.start = start;  assign if0.halt = halt;
    assign if0.step_mode = step_mode;  assign if0.step = step;
    assign if1.start = start;  assign if1.halt = halt;
    assign if1.step_mode = step_mode;  assign if1.step = step;
    assign if2.start = start;  assign if2.halt = halt;
    assign if2.step_mode = step_mode;  assign if2.step = step;

    cpu_run_ctrl #(.CNT_W(16), .RST_CYCLES(2), .MAX_CYCLES(50)) u0 (
        .clk(clk), .reset(reset), .bus(if0));
    cpu_run_ctrl #(.CNT_W(16), .RST_CYCLES(1), .MAX_CYCLES(5)) u1 (
        .clk(clk), .reset(reset), .bus(if1));
    cpu_run_ctrl #(.CNT_W(4), .RST_CYCLES(3), .MAX_CYCLES(0)) u2 (
        .clk(clk), .reset(reset), .bus(if2));

    obs_t act [3];
    assign act[0] = {if0.cpu_reset, if0.cpu_en, if0.done, if0.timeout, if0.cycles};
    assign act[1] = {if1.cpu_reset, if1.cpu_en, if1.done, if1.timeout, if1.cycles};
    assign act[2] = {if2.cpu_reset, if2.cpu_en, if2.done, if2.timeout, 12'd0, if2.cycles};

    // Reference model state
    int   m_ph  [3] = '{PH_IDLE, PH_IDLE, PH_IDLE};
    int   m_t0  [3] = '{0, 0, 0};
    int   m_cnt [3] = '{0, 0, 0};
    bit   m_to  [3] = '{0, 0, 0};
    int   ecnt = 0;

    obs_t sbq [3][$];
    dir_t dq[$];

    int n_cmp = 0;
    int n_bad = 0;

    function automatic int pick(input obs_t o, input int f);
        case (f)
            F_RST:   return int'(o.rst);
            F_EN:    return int'(o.en);
            F_DN:    return int'(o.dn);
            F_TO:    return int'(o.to);
            default: return int'(o.cyc);
        endcase
    endfunction

    function automatic string fname(input int f);
        case (f)
            F_RST:   return "cpu_reset";
            F_EN:    return "cpu_en";
            F_DN:    return "done";
            F_TO:    return "timeout";
            default: return "cycles";
        endcase
    endfunction

    // One clock of stimulus: drive inputs, queue what each instance should
    // show this cycle, then move the model across the coming edge.
    task automatic cyc(input bit st, input bit h, input bit sm, input bit sp, input bit rs);
        @(posedge clk);
        #1;
        start = st; halt = h; step_mode = sm; step = sp; reset = rs;
        for (int k = 0; k < 3; k++) begin
            obs_t e;
            bit   en;
            en    = (m_ph[k] == PH_RUN) && !h && (!sm || sp);
            e.rst = rs || (m_ph[k] == PH_IDLE) || (m_ph[k] == PH_RST);
            e.en  = en;
            e.dn  = (m_ph[k] == PH_DONE);
            e.to  = m_to[k];
            e.cyc = 16'((m_cnt[k] > PCAP[k]) ? PCAP[k] : m_cnt[k]);
            sbq[k].push_back(e);

            if (rs) begin
                m_ph[k] = PH_IDLE; m_cnt[k] = 0; m_to[k] = 0;
            end else begin
                case (m_ph[k])
                    PH_IDLE, PH_DONE:
                        if (st) begin
                            m_ph[k] = PH_RST; m_t0[k] = ecnt;
                            m_cnt[k] = 0; m_to[k] = 0;
                        end
                    PH_RST:
                        if (ecnt - m_t0[k] == PR[k]) m_ph[k] = PH_RUN;
                    default:
                        if (h) begin
                            m_ph[k] = PH_DONE;
                        end else if (en) begin
                            m_cnt[k]++;
                            if (PM[k] != 0 && m_cnt[k] == PM[k]) begin
                                m_ph[k] = PH_DONE; m_to[k] = 1;
                            end
                        end
                endcase
            end
        end
        ecnt++;
    endtask

    task automatic want(input int k, input int fld, input int val);
        dir_t d;
        d.k = k; d.fld = fld; d.val = val;
        dq.push_back(d);
    endtask

    // Monitor: every instance presents its status each cycle.
    obs_t mon_e;
    dir_t mon_d;
    int   mon_a;
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (sbq[k].size() > 0) begin
                mon_e = sbq[k].pop_front();
                n_cmp++;
                if (act[k] !== mon_e) begin
                    n_bad++;
                    $display("FAIL sb dut%0d t=%0t got rst=%b en=%b done=%b to=%b cyc=%0d, expected rst=%b en=%b done=%b to=%b cyc=%0d",
                             k, $time, act[k].rst, act[k].en, act[k].dn, act[k].to, act[k].cyc,
                             mon_e.rst, mon_e.en, mon_e.dn, mon_e.to, mon_e.cyc);
                end
            end
        end
        while (dq.size() > 0) begin
            mon_d = dq.pop_front();
            mon_a = pick(act[mon_d.k], mon_d.fld);
            n_cmp++;
            if (mon_a != mon_d.val) begin
                n_bad++;
                $display("FAIL dir %s dut%0d t=%0t got %0d expected %0d",
                         fname(mon_d.fld), mon_d.k, $time, mon_a, mon_d.val);
            end
        end
    end

    initial begin
        bit sm_r;
        bit pat [11] = '{1, 0, 1, 0, 0, 1, 0, 1, 1, 0, 0};

        // Reset state
        repeat (3) cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0);
        want(0, F_RST, 1); want(0, F_EN, 0); want(0, F_CYC, 0); want(0, F_DN, 0);

        // Budget run: dut0 hits 50, dut2 has no budget and saturates at 15
        cyc(1, 0, 0, 0, 0);
        for (int i = 1; i <= 62; i++) begin
            cyc(0, 0, 0, 0, 0);
            if (i <= 2)  want(0, F_RST, 1);
            if (i == 3)  begin want(0, F_RST, 0); want(0, F_EN, 1); end
            if (i == 52) want(0, F_EN, 1);
            if (i == 53) begin
                want(0, F_EN, 0); want(0, F_DN, 1); want(0, F_TO, 1); want(0, F_CYC, 50);
                want(1, F_CYC, 5); want(1, F_TO, 1);
            end
            if (i == 62) begin want(2, F_CYC, 15); want(2, F_TO, 0); want(2, F_DN, 0); end
        end
        cyc(0, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        want(2, F_DN, 1); want(2, F_CYC, 15); want(2, F_TO, 0);

        // Restart from DONE, then halt in dut0's 10th RUN cycle
        cyc(1, 0, 0, 0, 0);
        for (int i = 1; i <= 11; i++) begin
            cyc(0, 0, 0, 0, 0);
            if (i == 1) begin want(2, F_CYC, 0); want(2, F_DN, 0); want(2, F_RST, 1); end
        end
        cyc(0, 1, 0, 0, 0);
        want(0, F_EN, 0); want(0, F_CYC, 9);
        cyc(0, 0, 0, 0, 0);
        want(0, F_DN, 1); want(0, F_TO, 0); want(0, F_CYC, 9);

        // Halt coincides with dut1's last budget cycle
        cyc(1, 0, 0, 0, 0);
        repeat (5) cyc(0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0);
        want(1, F_EN, 0); want(1, F_CYC, 4);
        cyc(0, 0, 0, 0, 0);
        want(1, F_DN, 1); want(1, F_TO, 0); want(1, F_CYC, 4);

        // Step mode: 3 single pulses + one 2-cycle pulse
        cyc(1, 0, 1, 0, 0);
        repeat (2) cyc(0, 0, 1, 0, 0);
        for (int i = 0; i < 11; i++) cyc(0, 0, 1, pat[i], 0);
        cyc(0, 0, 1, 0, 0);
        want(0, F_CYC, 5); want(0, F_DN, 0); want(0, F_EN, 0);
        cyc(0, 1, 1, 0, 0);
        cyc(0, 0, 0, 0, 0);
        want(0, F_DN, 1);

        // Reset mid-RUN at cycles=20, then rerun from zero
        cyc(1, 0, 0, 0, 0);
        repeat (22) cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1);
        want(0, F_CYC, 20);
        cyc(1, 1, 0, 1, 0);
        want(0, F_CYC, 0); want(0, F_RST, 1); want(0, F_DN, 0); want(0, F_EN, 0);
        for (int i = 1; i <= 8; i++) begin
            cyc(0, 0, 0, 0, 0);
            if (i == 8) want(0, F_CYC, 5);
        end
        cyc(0, 1, 0, 0, 0);

        // Random traffic
        sm_r = 0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(39) == 0) sm_r = !sm_r;
            cyc($urandom_range(15) == 0, $urandom_range(23) == 0, sm_r,
                1'($urandom_range(1)), $urandom_range(249) == 0);
        end
        cyc(0, 0, 0, 0, 0);
        @(negedge clk);
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cpu_run_ctrl.md
CPU_RUN_CTRL -- requirements
Module: cpu_run_ctrl

Interface
REQ-001 The block SHALL have parameter CNT_W, default 16, meaning cycle-counter width in bits.
REQ-002 The block SHALL have parameter RST_CYCLES, default 2, meaning the number of cycles `cpu_reset` is held after start (legal range 1..255).
REQ-003 The block SHALL have parameter MAX_CYCLES, default 50, meaning the enabled-cycle budget, where 0 means unlimited (legal range 0..2^CNT_W-1).
REQ-004 The block SHALL have port `clk`, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-005 The block SHALL have port `reset`, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port `start`, input, 1 bit: a run request, sampled only in IDLE and DONE.
REQ-007 The block SHALL have port `halt`, input, 1 bit: the CPU's end-of-program indication.
REQ-008 The block SHALL have port `step_mode`, input, 1 bit: when 1, the CPU advances only on `step`.
REQ-009 The block SHALL have port `step`, input, 1 bit: a single-cycle advance request, used only when `step_mode`=1.
REQ-010 The block SHALL have port `cpu_reset`, output, 1 bit: reset to the CPU.
REQ-011 The block SHALL have port `cpu_en`, output, 1 bit: clock-enable to the CPU.
REQ-012 The block SHALL have port `cycles`, output, CNT_W bits: the count of enabled cycles in the current or last run.
REQ-013 The block SHALL have port `done`, output, 1 bit: the run has finished.
REQ-014 The block SHALL have port `timeout`, output, 1 bit: the run ended by budget exhaustion rather than `halt`.

Function
REQ-015 The FSM SHALL have exactly four states: IDLE, RST, RUN and DONE.
REQ-016 In IDLE, the block SHALL hold `cpu_reset`=1 and `cpu_en`=0, and on `start`=1 SHALL move to RST while clearing `cycles`, `done` and `timeout`.
REQ-017 In RST, the block SHALL hold `cpu_reset`=1 for exactly RST_CYCLES cycles (internal down-counter) and then move to RUN.
REQ-018 For `start` sampled at edge N, the state SHALL be RST during cycles N+1 .. N+RST_CYCLES, and `cpu_reset` SHALL first be 0 in cycle N+RST_CYCLES+1.
REQ-019 In RUN, `cpu_reset` SHALL be 0.
REQ-020 `cpu_en` SHALL be combinational and equal (state==RUN) AND NOT `halt` AND (NOT `step_mode` OR `step`).
REQ-021 `step` SHALL be level-sampled, and a `step` held high N cycles SHALL give N enabled cycles (no edge detection).
REQ-022 `cycles` SHALL increment by 1 on each edge where `cpu_en`=1, SHALL saturate at 2^CNT_W-1 (no wrap), and SHALL remain unchanged in all other cycles.
REQ-023 `halt`=1 in RUN SHALL cause a move to DONE at the next edge, with `timeout`=0 and `cycles` not incremented.
REQ-024 When MAX_CYCLES≠0, an enabled cycle with `cycles`==MAX_CYCLES-1 SHALL be the last one: the next state SHALL be DONE with `timeout`=1 and `cycles`=MAX_CYCLES, so exactly MAX_CYCLES enabled cycles execute.
REQ-025 If `halt` and the last budget cycle coincide, `halt` SHALL win: `cpu_en`=0, `timeout`=0, `cycles`=MAX_CYCLES-1.
REQ-026 In DONE, the block SHALL have `done`=1, `cpu_en`=0 and `cpu_reset`=0 (CPU state is preserved for inspection), and `cycles` and `timeout` SHALL be held.
REQ-027 `start`=1 in DONE SHALL restart exactly as from IDLE (move to RST, clear `cycles`, `done` and `timeout`).
REQ-028 `start` SHALL be ignored in RST and RUN.
REQ-029 `step_mode` changes SHALL take effect in the same cycle, because `cpu_en` is combinational.
REQ-030 When MAX_CYCLES=0, the block SHALL never assert `timeout`, and the run SHALL end only on `halt`, with `cycles` saturating.

Reset
REQ-031 `reset`=1 at an edge SHALL force state IDLE, `cpu_reset`=1, `cpu_en`=0, `cycles`=0, `done`=0, `timeout`=0 and the RST down-counter to 0, in any state including mid-RUN and mid-RST.
REQ-032 `reset` SHALL take priority over `start`, `halt` and `step` in the same cycle.
REQ-033 During reset and in IDLE, `cpu_reset` SHALL be 1, so the CPU is held in reset from power-up.

Verification
REQ-034 Budget run: defaults, `start` pulse at edge 0, `halt`=0, `step_mode`=0 -> `cpu_reset` high through cycle 2, `cpu_en` high for exactly 50 cycles, then `done`=1, `timeout`=1, `cycles`=50.
REQ-035 Halt run: `halt` raised in the 10th RUN cycle -> 9 enabled cycles, `done`=1, `timeout`=0, `cycles`=9.
REQ-036 Coincident halt and budget: MAX_CYCLES=5, `halt` raised in the 5th RUN cycle -> `cycles`=4, `timeout`=0, `done`=1.
REQ-037 Step mode: `step_mode`=1, 3 single-cycle `step` pulses plus one 2-cycle `step` pulse -> `cycles`=5, `cpu_en` never high without `step`.
REQ-038 Reset mid-RUN: `reset` asserted with `cycles`=20 -> next cycle IDLE, `cycles`=0, `cpu_reset`=1, `done`=0; a subsequent `start` reruns from zero.
REQ-039 Saturation and restart: CNT_W=4, MAX_CYCLES=0, 20 enabled cycles -> `cycles`=15, `timeout`=0; `halt` then `start` -> `cycles` cleared, `done`=0, RST entered.
